// File: rtl/rv32_e_div_unit_pkg.sv
// Shared ALU op codes, divider FSM state encodings and the latched-op record.
// Consumed by rv32_e_div_unit and rv32_e_div_core via import rv32_e_div_unit_pkg::*.
package rv32_e_div_unit_pkg;

    localparam int ALU_W = 6;

    localparam logic [ALU_W-1:0] ALU_ADD  = 6'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 6'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 6'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 6'd3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 6'd4;
    localparam logic [ALU_W-1:0] ALU_SLL  = 6'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 6'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 6'd7;
    localparam logic [ALU_W-1:0] ALU_SLT  = 6'd8;
    localparam logic [ALU_W-1:0] ALU_SLTU = 6'd9;
    localparam logic [ALU_W-1:0] ALU_MUL  = 6'd12;
    localparam logic [ALU_W-1:0] ALU_DIV  = 6'd16;
    localparam logic [ALU_W-1:0] ALU_DIVU = 6'd17;
    localparam logic [ALU_W-1:0] ALU_REM  = 6'd18;
    localparam logic [ALU_W-1:0] ALU_REMU = 6'd19;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic rem;    // result is the remainder rather than the quotient
        logic neg_q;  // quotient must be negated in FIX
        logic neg_r;  // remainder must be negated in FIX
        logic div0;   // divisor was zero
    } div_op_t;

    function automatic logic is_div_op(input logic [ALU_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/rv32_e_div_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step_i cycle.
// load_i seeds the partial remainder, quotient shift register and step counter.
module rv32_e_div_core
    import rv32_e_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            last_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            fits;

    // When the trial fits, the difference is below the divisor, so XLEN bits suffice.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        fits    = shifted >= {1'b0, dvs_q};
        sub     = shifted[XLEN-1:0] - dvs_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= fits ? sub : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == LAST_CNT);

endmodule

// File: rtl/rv32_e_div_unit.sv
// RV32 divide/remainder unit: IDLE -> BUSY (XLEN steps) -> FIX (signs) -> DONE.
// Optional macro DIV_FAST_PATH_EN sends divide-by-zero and signed overflow IDLE -> DONE.
module rv32_e_div_unit
    import rv32_e_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [ALU_W-1:0] alu_control_i,
    input  logic [XLEN-1:0]  src_a_i,
    input  logic [XLEN-1:0]  src_b_i,
    input  logic             flush_i,
    output logic             stall_cpu_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [1:0]       dbg_state_o
);
    localparam logic [XLEN-1:0] ONE = XLEN'(1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    div_op_t         op_q, op_d;
    logic [XLEN-1:0] fix_res_q, result_q;
    logic [XLEN-1:0] fix_res_d, fast_res;
    logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [XLEN-1:0] core_quo, core_rem;
    logic            signed_op, accept, b_zero, skip_iter, core_last;

    // Handshake: an op is taken in the IDLE cycle where start_i is high with a
    // divide code and flush_i is low; done_o then pulses exactly once with result_o valid.
    always_comb begin
        signed_op = (alu_control_i == ALU_DIV) || (alu_control_i == ALU_REM);
        b_zero    = (src_b_i == '0);
        accept    = (state_q == ST_IDLE) && start_i && is_div_op(alu_control_i) && !flush_i;
        op_d.rem  = (alu_control_i == ALU_REM) || (alu_control_i == ALU_REMU);
        op_d.neg_q = signed_op && (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]);
        op_d.neg_r = signed_op && src_a_i[XLEN-1];
        op_d.div0  = b_zero;
        a_mag = (signed_op && src_a_i[XLEN-1]) ? (~src_a_i + ONE) : src_a_i;
        b_mag = (signed_op && src_b_i[XLEN-1]) ? (~src_b_i + ONE) : src_b_i;
    end

`ifdef DIV_FAST_PATH_EN
    logic ovf;
    always_comb begin
        ovf       = signed_op && (src_a_i == MIN) && (src_b_i == '1);
        skip_iter = b_zero || ovf;
        if (b_zero) fast_res = op_d.rem ? src_a_i : '1;
        else        fast_res = op_d.rem ? '0 : MIN;
    end
`else
    always_comb begin
        skip_iter = 1'b0;
        fast_res  = '0;
    end
`endif

    rv32_e_div_core #(.XLEN(XLEN)) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .step_i      (state_q == ST_BUSY),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .last_o      (core_last)
    );

    // A zero divisor leaves an all-ones quotient; the signed fix must not flip it.
    always_comb begin
        quo_fix   = op_q.div0 ? '1 : (op_q.neg_q ? (~core_quo + ONE) : core_quo);
        rem_fix   = op_q.neg_r ? (~core_rem + ONE) : core_rem;
        fix_res_d = op_q.rem ? rem_fix : quo_fix;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = skip_iter ? ST_DONE : ST_BUSY;
                ST_BUSY: if (core_last) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            fix_res_q <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= op_d;
                if (skip_iter) fix_res_q <= fast_res;
            end
            if (state_q == ST_FIX && !flush_i) fix_res_q <= fix_res_d;
            if (state_q == ST_DONE && !flush_i) result_q <= fix_res_q;
        end
    end

    // result_q only commits when the DONE pulse is not flushed away.
    assign done_o      = (state_q == ST_DONE) && !flush_i;
    assign result_o    = done_o ? fix_res_q : result_q;
    assign stall_cpu_o = !rst_i && (accept || state_q == ST_BUSY || state_q == ST_FIX);
    assign dbg_state_o = state_q;

endmodule

// File: doc/rv32_e_div_unit.md
RV32_E_DIV_UNIT -- requirements
Module: rv32_e_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request qualifier from execute stage.
REQ-005 SHALL have port alu_control_i  input  6  op code; only ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU are accepted.
REQ-006 SHALL have port src_a_i  input  XLEN  dividend.
REQ-007 SHALL have port src_b_i  input  XLEN  divisor.
REQ-008 SHALL have port flush_i  input  1  abort in-flight op.
REQ-009 SHALL have port stall_cpu_o  output  1  hold pipeline while op outstanding.
REQ-010 SHALL have port done_o  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port result_o  output  XLEN  quotient or remainder per op.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-013 SHALL accept an op only in IDLE when start_i=1 and alu_control_i is one of the four div ops; other codes and starts in other states are ignored.
REQ-014 On accept SHALL latch op, signedness, operand magnitudes and result signs; IDLE->BUSY.
REQ-015 BUSY SHALL run exactly XLEN radix-2 restoring iterations on unsigned magnitudes, then ->FIX.
REQ-016 FIX SHALL apply sign: quotient negated if signs of a,b differ (signed ops); remainder takes sign of dividend; ->DONE.
REQ-017 DONE SHALL assert done_o for one cycle, update result_o, then ->IDLE.
REQ-018 Normal latency SHALL be XLEN+2 cycles from accepting edge to done_o (34 for XLEN=32).
REQ-019 Divide by zero SHALL yield quotient all-ones, remainder = src_a_i, for signed and unsigned ops.
REQ-020 Signed overflow (0x80000000 / -1) SHALL yield quotient 0x80000000, remainder 0.
REQ-021 stall_cpu_o SHALL be high combinationally in the accepting cycle and in BUSY and FIX, low in IDLE (non-accepting) and DONE.
REQ-022 result_o SHALL hold its last value until the next DONE.
REQ-023 flush_i=1 SHALL force IDLE on the next edge from any state, suppress done_o, leave result_o unchanged; flush_i has priority over start_i in the same cycle.
REQ-024 start_i coincident with DONE SHALL be ignored; a new op is accepted no earlier than the following IDLE cycle.

Reset
REQ-025 rst_i SHALL immediately force state IDLE, done_o=0, result_o=0, all internal registers 0; stall_cpu_o=0 while rst_i high.
REQ-026 Reset mid-operation SHALL discard the op with no done_o pulse.

Configuration
REQ-027 Macro DIV_FAST_PATH_EN defined: divide-by-zero and signed overflow go IDLE->DONE directly, done_o one cycle after accept, stall_cpu_o high only in the accepting cycle.
REQ-028 Macro undefined: those cases SHALL take the full XLEN+2 latency with identical result values.

Structure
REQ-029 ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU encodings and the state enum SHALL live in the shared defines package alongside existing ALU codes.
REQ-030 The unsigned iteration datapath (partial remainder, quotient shift, counter) SHALL be sub-module rv32_e_div_core; sign handling and FSM remain in rv32_e_div_unit.

Verification
REQ-031 DIV 100 / -7 -> done_o at cycle 34, result_o 0xFFFFFFF2 (-14); REM same operands -> 2.
REQ-032 DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU -> 1.
REQ-033 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; latency 1 cycle with DIV_FAST_PATH_EN, 34 without.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 flush_i at cycle 10 of DIVU -> no done_o, stall_cpu_o low next cycle, result_o unchanged; new op then completes correctly.
REQ-036 rst_i asserted mid-BUSY -> outputs zero immediately; start_i with ALU_ADD code -> ignored, stall_cpu_o stays 0.
